neuron_seq: RTL and testbench
=============================

# neuron_seq

Time-multiplexed, parametrised successor of the 4-input combinational neuron. It computes one signed weighted sum of N_IN unsigned activations plus a signed bias, using a single shared multiplier over N_IN cycles. It then applies the ReLU/saturate/scale activation and returns one unsigned result through valid/ready handshakes. It sits between layer-input buffering and the next layer of the Morse decoder network, where it replaces fixed 4-input neurons for wider layers.

## Interface
Parameters:
- N_IN, 4: number of inputs per neuron (≥1)
- IN_W, 8: unsigned activation width
- W_W, 7: signed weight and bias width
- ACC_W, 19: signed accumulator width; must be ≥ IN_W+1+W_W+clog2(N_IN+1)
- SHIFT, 2: output scale; result field is acc[SHIFT+OUT_W-1:SHIFT]
- OUT_W, 8: unsigned output width; SHIFT+OUT_W ≤ ACC_W-1

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input vector and weights are valid
- in_ready  out  1  block can accept a vector (high only in IDLE)
- in_data  in  N_IN*IN_W  activations; input 0 occupies the MSBs
- weight  in  (N_IN+1)*W_W  weight 0 occupies the MSBs, then weights 1..N_IN-1, then the bias in the LSBs
- out_valid  out  1  result is valid
- out_ready  in  1  downstream accepts the result
- out_data  out  OUT_W  activated result

## Operation
- States:
  - IDLE: in_ready=1.
  - MAC: runs for N_IN cycles, one product per cycle.
  - OUT: out_valid=1, out_data stable.
- IDLE→MAC on in_valid&in_ready. At this point in_data and weight are captured into internal registers; the accumulator is loaded with the sign-extended bias; the index is cleared to 0.
- In MAC, each cycle adds w[idx]*{1'b0,in[idx]} (signed, IN_W+W_W+1 bits, sign-extended to ACC_W) to the accumulator, then increments idx.
  - Inputs are processed in order 0..N_IN-1.
  - When idx==N_IN-1 the state goes to OUT, and the activation of the final sum is registered into out_data in the same edge.
- Activation on the final sum pre:
  - If pre[ACC_W-1]=1 (negative), the result is 0.
  - Otherwise, if any bit of pre[ACC_W-2:SHIFT+OUT_W] is set, the result is all-ones (saturate).
  - Otherwise, the result is pre[SHIFT+OUT_W-1:SHIFT].
- OUT→IDLE on out_valid&out_ready. out_data holds its value until the next result is loaded.
- in_valid is ignored outside IDLE. Upstream must hold in_valid until accepted.
- Reset in any state forces IDLE, out_valid=0, in_ready=1 (from the next cycle), out_data=0, accumulator=0, idx=0. A partial sum is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0.
- Latency: vector accepted at edge T → out_valid high in the cycle after edge T+N_IN (N_IN+1 cycles).
- Throughput: at most one result per N_IN+2 cycles when out_ready is held high. The block does not accept a new vector in the same cycle as an output handshake.
- out_data and out_valid are registered. in_ready is decoded directly from the state register, with no combinational path from in_valid or out_ready.
- Back-pressure: with out_ready low, the block stays in OUT indefinitely, with out_data constant and in_ready=0.
- N_IN=1: MAC lasts exactly one cycle.

## Configuration
- NEURON_ROUND_EN:
  - Defined: before activation, 2^(SHIFT-1) is added to pre (only if SHIFT>0). Negative and saturation checks use the rounded value, so the result is round-half-up.
  - Undefined: plain truncation, bit-exact with the legacy combinational neuron.

## Test plan
- Default parameters; all weights 1, bias 0, all inputs 255 → pre=1020, out_data=255, out_valid asserted 5 cycles after accept.
- All weights 63, inputs 255 → pre=64260 → saturates, out_data=255. All weights -64, inputs 10 → negative, out_data=0.
- Bias 3, inputs 0 → out_data=0 without NEURON_ROUND_EN, 1 with it. Bias 63 → 15 without rounding, 16 with it.
- out_ready held low 10 cycles after out_valid → out_data constant, in_ready=0, a second in_valid is ignored. Raising out_ready gives a handshake, then in_ready=1 on the next cycle.
- Assert rst during the 2nd MAC cycle → next cycle in IDLE with out_valid=0 and out_data=0. A fresh vector then produces the correct result with no residue from the aborted sum.
- N_IN=8, IN_W=8, W_W=8, ACC_W=21: random vectors are compared against a reference model, including back-to-back accepts with out_ready tied high (one result every 10 cycles).

Source files
------------

// File: rtl/neuron_seq.sv
// neuron_seq: time-multiplexed N_IN-input neuron with a single shared multiplier and ReLU/saturate/scale output; define NEURON_ROUND_EN for round-half-up scaling
module neuron_seq #(
    parameter int N_IN  = 4,
    parameter int IN_W  = 8,
    parameter int W_W   = 7,
    parameter int ACC_W = 19,
    parameter int SHIFT = 2,
    parameter int OUT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_IN*IN_W-1:0]     in_data,
    input  logic [(N_IN+1)*W_W-1:0]  weight,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data
);
    localparam int IW  = N_IN > 1 ? $clog2(N_IN) : 1;
    localparam int P_W = IN_W + W_W + 1;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                   state, state_n;
    logic [N_IN*IN_W-1:0]     in_r;
    logic [N_IN*W_W-1:0]      w_r;
    logic signed [ACC_W-1:0]  acc, sum, pre;
    logic [ACC_W-1:0]         hi;
    logic signed [P_W-1:0]    prod;
    logic [IW-1:0]            idx;
    logic                     last;
    logic [OUT_W-1:0]         act;

    assign in_ready  = state == IDLE;
    assign out_valid = state == OUT;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next state: accept in IDLE, N_IN MAC cycles, hold OUT until taken
    always_comb begin
        state_n = state;
        state_n = (state == IDLE && in_valid)  ? MAC  :
                  (state == MAC  && last)      ? OUT  :
                  (state == OUT  && out_ready) ? IDLE : state;
    end

    // product of the current (MSB-aligned) operand pair, running sum and activation of it
    always_comb begin
        prod = P_W'($signed(w_r[N_IN*W_W-1 -: W_W])) * $signed({1'b0, in_r[N_IN*IN_W-1 -: IN_W]});
        sum  = acc + ACC_W'(prod);
`ifdef NEURON_ROUND_EN
        pre  = sum + ACC_W'((2**SHIFT) / 2);
`else
        pre  = sum;
`endif
        hi   = $unsigned(pre) >> (SHIFT + OUT_W);
        act  = pre[ACC_W-1] ? '0 : (|hi) ? '1 : pre[SHIFT+OUT_W-1:SHIFT];
        last = idx == IW'(N_IN - 1);
    end

    // operand shift registers, accumulator, index and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            in_r     <= '0;
            w_r      <= '0;
            acc      <= '0;
            idx      <= '0;
            out_data <= '0;
        end else if (state == IDLE && in_valid) begin
            in_r <= in_data;
            w_r  <= weight[(N_IN+1)*W_W-1:W_W];
            acc  <= ACC_W'($signed(weight[W_W-1:0]));
            idx  <= '0;
        end else if (state == MAC) begin
            in_r <= in_r << IN_W;
            w_r  <= w_r << W_W;
            acc  <= sum;
            idx  <= idx + IW'(1);
            if (last) out_data <= act;
        end
    end
endmodule

// File: tb/tb_neuron_seq.sv
// tb_neuron_seq: directed checks of neuron_seq at default size and at N_IN=8 with back-to-back vectors
module tb_neuron_seq;
`ifdef NEURON_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic        clk = 0, rst = 1;
    logic        in_valid = 0, out_ready = 0;
    logic [31:0] in_data = '0;
    logic [34:0] weight = '0;
    logic        in_ready, out_valid;
    logic [7:0]  out_data;

    logic        in8_valid = 0;
    logic [63:0] in8_data = '0;
    logic [71:0] w8 = '0;
    logic        in8_ready, out8_valid;
    logic [7:0]  out8_data;

    int errs = 0, checks = 0, cyc = 0;
    logic [63:0] vd[6];
    logic [71:0] vw[6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    neuron_seq u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .weight(weight), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
    );

    neuron_seq #(.N_IN(8), .IN_W(8), .W_W(8), .ACC_W(21), .SHIFT(2), .OUT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in8_valid), .in_ready(in8_ready),
        .in_data(in8_data), .weight(w8), .out_valid(out8_valid),
        .out_ready(1'b1), .out_data(out8_data)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pd(input int a, b, c, d);
        return {8'(a), 8'(b), 8'(c), 8'(d)};
    endfunction

    function automatic logic [34:0] pw(input int a, b, c, d, e);
        return {7'(a), 7'(b), 7'(c), 7'(d), 7'(e)};
    endfunction

    function automatic int model8(input logic [63:0] d, input logic [71:0] w);
        int a;
        a = int'($signed(w[7:0]));
        for (int i = 0; i < 8; i++) a += int'($signed(w[71-8*i -: 8])) * int'(d[63-8*i -: 8]);
        if (RND) a += 2;
        if (a < 0) return 0;
        if ((a >> 2) > 255) return 255;
        return a >> 2;
    endfunction

    task automatic send(input logic [31:0] d, input logic [34:0] w);
        @(negedge clk);
        in_data  = d;
        weight   = w;
        in_valid = 1;
        check("in_ready_before_accept", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic result(input string tag, input int exp);
        int n;
        wait_out(n);
        check({tag, "_latency"}, n, 5);
        check(tag, out_data, exp);
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        @(negedge clk);
        check({tag, "_idle"}, in_ready, 1);
    endtask

    initial begin
        int n, ta, tp;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);

        send(pd(255, 255, 255, 255), pw(1, 1, 1, 1, 0));
        result("ones", 255);
        send(pd(255, 255, 255, 255), pw(63, 63, 63, 63, 0));
        result("sat63", 255);
        send(pd(10, 10, 10, 10), pw(-64, -64, -64, -64, 0));
        result("neg", 0);
        send(pd(0, 0, 0, 0), pw(0, 0, 0, 0, 3));
        result("bias3", RND ? 1 : 0);
        send(pd(0, 0, 0, 0), pw(0, 0, 0, 0, 63));
        result("bias63", RND ? 16 : 15);
        send(pd(1, 2, 3, 4), pw(1, 2, 3, 4, 0));
        result("order", RND ? 8 : 7);
        send(pd(255, 255, 255, 255), pw(1, 1, 1, 1, 4));
        result("sat_edge", 255);
        send(pd(0, 0, 0, 0), pw(0, 0, 0, 0, -1));
        result("minus1", 0);
        send(pd(100, 50, 0, 200), pw(-3, 5, 7, 1, -10));
        result("mixed", 35);

        send(pd(1, 2, 3, 4), pw(1, 2, 3, 4, 0));
        wait_out(n);
        check("bp_latency", n, 5);
        in_data  = pd(0, 0, 0, 0);
        weight   = pw(0, 0, 0, 0, 63);
        in_valid = 1;
        repeat (10) @(negedge clk);
        check("bp_out_data", out_data, RND ? 8 : 7);
        check("bp_out_valid", out_valid, 1);
        check("bp_in_ready", in_ready, 0);
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        @(negedge clk);
        check("bp_after_hs_in_ready", in_ready, 1);
        check("bp_after_hs_out_valid", out_valid, 0);
        @(posedge clk);
        #1 in_valid = 0;
        result("bp_next", RND ? 16 : 15);

        send(pd(255, 255, 255, 255), pw(63, 63, 63, 63, 0));
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_data", out_data, 0);
        send(pd(1, 2, 3, 4), pw(1, 2, 3, 4, 0));
        result("after_abort", RND ? 8 : 7);

        vd[0] = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        vw[0] = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd0};
        vd[1] = {8{8'hff}};
        vw[1] = {{8{8'd127}}, 8'd0};
        for (int k = 2; k < 6; k++)
            for (int i = 0; i < 8; i++) begin
                vd[k][8*i +: 8] = 8'($urandom_range(0, 63));
                vw[k][8*i +: 8] = 8'(int'($urandom_range(0, 31)) - 16);
                vw[k][71:64]    = 8'(int'($urandom_range(0, 255)) - 128);
            end
        @(negedge clk);
        in8_data  = vd[0];
        w8        = vw[0];
        in8_valid = 1;
        tp = 0;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (!in8_ready && n < 30) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk);
            #1 ta = cyc;
            if (k > 0) check("gap8", ta - tp, 10);
            tp = ta;
            if (k < 5) begin
                in8_data = vd[k+1];
                w8       = vw[k+1];
            end else in8_valid = 0;
            n = 0;
            while (!out8_valid && n < 30) begin
                @(negedge clk);
                n++;
            end
            check("lat8", n, 9);
            check("out8", out8_data, model8(vd[k], vw[k]));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
